// File: rtl/muldiv_seq_ex.sv
// Iterative unsigned multiply/divide unit for the RV32 EX stage (MUL, MULHU, DIVU, REMU).
// Each op takes one bit per cycle, and the unit stalls IF/ID/EX while the op is in flight.
module muldiv_seq_ex #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_EX,
  input  logic [1:0]       i_op_EX,
  input  logic [WIDTH-1:0] i_srcA_EX,
  input  logic [WIDTH-1:0] i_srcB_EX,
  input  logic             i_flush_EX,
  output logic             o_stall_EX,
  output logic             o_busy_EX,
  output logic             o_done_EX,
  output logic [WIDTH-1:0] o_result_EX
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] opnd_r;    // multiplicand or divisor
  logic [WIDTH-1:0] hi_r;      // product high half or remainder
  logic [WIDTH-1:0] lo_r;      // multiplier/product low half or dividend/quotient
  logic             done_r;
  logic             busy_r;
  logic [WIDTH-1:0] result_r;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH-1:0] hi_nxt_s;
  logic [WIDTH-1:0] lo_nxt_s;
  logic             last_s;
  logic             div_zero_s;

  assign last_s     = (cnt_r == CW'(WIDTH - 1));
  assign div_zero_s = i_op_EX[1] && (i_srcB_EX == {WIDTH{1'b0}});

  // One shift-add (multiply) or restoring-subtract (divide) iteration.
  always_comb begin
    add_s    = {(WIDTH+1){1'b0}};
    shl_s    = {(WIDTH+1){1'b0}};
    sub_s    = {(WIDTH+1){1'b0}};
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (op_r[1] == 1'b0) begin
      add_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      hi_nxt_s = add_s[WIDTH:1];
      lo_nxt_s = {add_s[0], lo_r[WIDTH-1:1]};
    end else begin
      shl_s = {hi_r, lo_r[WIDTH-1]};
      sub_s = shl_s - {1'b0, opnd_r};
      if (shl_s >= {1'b0, opnd_r}) begin
        hi_nxt_s = sub_s[WIDTH-1:0];
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt_s = shl_s[WIDTH-1:0];
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sequencer FSM with registered done/busy/result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      op_r     <= 2'b00;
      opnd_r   <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else if (i_flush_EX) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (i_start_EX) begin
            op_r  <= i_op_EX;
            cnt_r <= {CW{1'b0}};
            hi_r  <= {WIDTH{1'b0}};
            if (div_zero_s) begin
              state_r  <= ST_DONE;
              done_r   <= 1'b1;
              busy_r   <= 1'b0;
              opnd_r   <= {WIDTH{1'b0}};
              lo_r     <= {WIDTH{1'b0}};
              result_r <= i_op_EX[0] ? i_srcA_EX : {WIDTH{1'b1}};
            end else begin
              state_r <= ST_BUSY;
              busy_r  <= 1'b1;
              opnd_r  <= i_op_EX[1] ? i_srcB_EX : i_srcA_EX;
              lo_r    <= i_op_EX[1] ? i_srcA_EX : i_srcB_EX;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_BUSY: begin
          hi_r  <= hi_nxt_s;
          lo_r  <= lo_nxt_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= op_r[0] ? hi_nxt_s : lo_nxt_s;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_DONE: begin
          // The finishing instruction is still in EX, so a held start is not a new op.
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_stall_EX  = i_rst_n & ~i_flush_EX &
                       (((state_r == ST_IDLE) & i_start_EX) | busy_r);
  assign o_busy_EX   = busy_r;
  assign o_done_EX   = done_r;
  assign o_result_EX = result_r;

endmodule

// File: tb/tb_muldiv_seq_ex.sv
// Scoreboard bench for muldiv_seq_ex: directed ops push expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq_ex;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   cyc;

  muldiv_seq_ex #(.WIDTH(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start_EX (start),
    .i_op_EX    (op),
    .i_srcA_EX  (src_a),
    .i_srcB_EX  (src_b),
    .i_flush_EX (flush),
    .o_stall_EX (stall),
    .o_busy_EX  (busy),
    .o_done_EX  (done),
    .o_result_EX(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result 0x%08h with empty scoreboard (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int  t0;
    bit  got;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    t0    = cyc;
    sb_q.push_back('{exp, t0 + lat});
    got = 1'b0;
    for (int k = 0; k <= lat + 5 && !got; k++) begin
      @(negedge clk);
      if (k <= lat) chk("stall", {31'd0, stall}, {31'd0, (k < lat)});
      if (k == 3) begin
        src_a = 32'h1234_5678;
        src_b = 32'h0000_0003;
      end
      if (done) got = 1'b1;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    src_a  = 32'd0;
    src_b  = 32'd0;
    flush  = 1'b0;

    #12;
    start = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 32'd7, 32'd6, 32'd42, 33);
    go_idle();
    repeat (3) @(negedge clk);
    chk("result_hold", result, 32'd42);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run_op(2'b01, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33);
    run_op(2'b10, 32'd100, 32'd7, 32'd14, 33);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op(2'b11, 32'hDEAD_BEEF, 32'h10, 32'h0000_000F, 33);
    run_op(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op(2'b11, 32'd5, 32'd0, 32'd5, 1);
    go_idle();

    // Flush while BUSY with cnt=10: no done, result keeps 5.
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'd11;
    src_b = 32'd13;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_busy_in_cycle", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_result_kept", result, 32'd5);

    // Async reset mid-BUSY, between edges.
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'd9;
    src_b = 32'd9;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 32'd3, 32'd3, 32'd9, 33);
    go_idle();
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
